// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate / occupancy controller.
package parking_pkg;

  localparam int COUNT_W             = 8;
  localparam int TIMER_W             = 8;
  localparam int DEFAULT_CAPACITY    = 200;
  localparam int DEFAULT_GATE_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    CLOSE    = 2'd3
  } state_e;

  function automatic logic rise_of(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/parking_occupancy_ctrl_rise_edge_detect.sv
// Rising-edge detector for one level sensor: registered history, combinational rise.
import parking_pkg::*;

module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // History follows the sensor every cycle regardless of controller state.
  always_comb begin
    prev_d = sig_in;
  end

  // History register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = rise_of(sig_in, prev_q);

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Barrier sequencing FSM and occupancy counter; count/load_en feed the
// downstream occupancy register's D/en pins directly.
import parking_pkg::*;

module parking_occupancy_ctrl #(
  parameter int CAPACITY    = DEFAULT_CAPACITY,
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic               car_passed,
  output logic [COUNT_W-1:0] count,
  output logic               load_en,
  output logic               gate_open,
  output logic               gate_dir,
  output logic               reject,
  output logic               full,
  output logic               empty
);

  localparam logic [COUNT_W-1:0] CAP_C      = COUNT_W'(CAPACITY);
  localparam logic [COUNT_W-1:0] COUNT_ZERO = COUNT_W'(0);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 load_en_q, load_en_d;
  logic                 gate_open_q, gate_open_d;
  logic                 gate_dir_q, gate_dir_d;
  logic                 reject_q, reject_d;

  logic entry_rise;
  logic exit_rise;
  logic pass_rise;

  rise_edge_detect u_entry_edge (
    .clk    (CLK),
    .rst_n  (RST),
    .sig_in (entry_req),
    .rise   (entry_rise)
  );

  rise_edge_detect u_exit_edge (
    .clk    (CLK),
    .rst_n  (RST),
    .sig_in (exit_req),
    .rise   (exit_rise)
  );

  rise_edge_detect u_pass_edge (
    .clk    (CLK),
    .rst_n  (RST),
    .sig_in (car_passed),
    .rise   (pass_rise)
  );

  // Next-state, counter and output decode; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timer_d     = timer_q;
    load_en_d   = 1'b0;
    gate_open_d = gate_open_q;
    gate_dir_d  = gate_dir_q;
    reject_d    = 1'b0;

    case (state_q)
      IDLE: begin
        gate_open_d = 1'b0;
        // Exit has priority; a coincident entry edge is dropped, not queued.
        if (exit_rise) begin
          if (count_q != COUNT_ZERO) begin
            state_d     = OPEN_OUT;
            gate_open_d = 1'b1;
            gate_dir_d  = 1'b1;
            timer_d     = TIMER_ZERO;
          end else begin
            reject_d = 1'b1;
          end
        end else if (entry_rise) begin
          if (count_q < CAP_C) begin
            state_d     = OPEN_IN;
            gate_open_d = 1'b1;
            gate_dir_d  = 1'b0;
            timer_d     = TIMER_ZERO;
          end else begin
            reject_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      OPEN_IN, OPEN_OUT: begin
        if (pass_rise) begin
          state_d     = CLOSE;
          gate_open_d = 1'b0;
          if (state_q == OPEN_IN) begin
            if (count_q < CAP_C) begin
              count_d   = count_q + COUNT_ONE;
              load_en_d = 1'b1;
            end else begin
              count_d = count_q;
            end
          end else begin
            if (count_q != COUNT_ZERO) begin
              count_d   = count_q - COUNT_ONE;
              load_en_d = 1'b1;
            end else begin
              count_d = count_q;
            end
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d     = IDLE;
          gate_open_d = 1'b0;
          timer_d     = TIMER_ZERO;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      CLOSE: begin
        state_d     = IDLE;
        gate_open_d = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        gate_open_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      count_q     <= COUNT_ZERO;
      timer_q     <= TIMER_ZERO;
      load_en_q   <= 1'b0;
      gate_open_q <= 1'b0;
      gate_dir_q  <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      load_en_q   <= load_en_d;
      gate_open_q <= gate_open_d;
      gate_dir_q  <= gate_dir_d;
      reject_q    <= reject_d;
    end
  end

  assign count     = count_q;
  assign load_en   = load_en_q;
  assign gate_open = gate_open_q;
  assign gate_dir  = gate_dir_q;
  assign reject    = reject_q;
  assign full      = (count_q == CAP_C);
  assign empty     = (count_q == COUNT_ZERO);

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Bench for parking_occupancy_ctrl: fixed vector table, directed corner sequences,
// then random sensor traffic checked against a countdown-based reference model.
module tb_parking_occupancy_ctrl;

  localparam int CAP  = 6;
  localparam int GATE = 16;

  logic       CLK;
  logic       RST;
  logic       entry_req;
  logic       exit_req;
  logic       car_passed;
  logic [7:0] count;
  logic       load_en;
  logic       gate_open;
  logic       gate_dir;
  logic       reject;
  logic       full;
  logic       empty;

  int n_checks;
  int n_err;

  parking_occupancy_ctrl #(
    .CAPACITY    (CAP),
    .GATE_CYCLES (GATE)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .car_passed (car_passed),
    .count      (count),
    .load_en    (load_en),
    .gate_open  (gate_open),
    .gate_dir   (gate_dir),
    .reject     (reject),
    .full       (full),
    .empty      (empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: "phase" 0 idle, 1 admitting, 2 releasing, 3 guard.
  // The gate is modelled as a budget of remaining open cycles.
  int   m_phase;
  int   m_count;
  int   m_left;
  logic m_load, m_open, m_dir, m_rej;
  logic h_e, h_x, h_p;

  task automatic model_edge(input logic r, input logic e, input logic x, input logic p);
    logic er, xr, pr;
    if (!r) begin
      m_phase = 0; m_count = 0; m_left = 0;
      m_load = 0; m_open = 0; m_dir = 0; m_rej = 0;
      h_e = 0; h_x = 0; h_p = 0;
      return;
    end
    er = e && !h_e;  xr = x && !h_x;  pr = p && !h_p;
    h_e = e; h_x = x; h_p = p;
    m_load = 0; m_rej = 0;
    if (m_phase == 0) begin
      if (xr) begin
        if (m_count > 0) begin m_phase = 2; m_open = 1; m_dir = 1; m_left = GATE; end
        else m_rej = 1;
      end else if (er) begin
        if (m_count < CAP) begin m_phase = 1; m_open = 1; m_dir = 0; m_left = GATE; end
        else m_rej = 1;
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      if (pr) begin
        if (m_phase == 1 && m_count < CAP) begin m_count++; m_load = 1; end
        if (m_phase == 2 && m_count > 0)   begin m_count--; m_load = 1; end
        m_open = 0; m_phase = 3;
      end else begin
        m_left--;
        if (m_left == 0) begin m_open = 0; m_phase = 0; end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic x, input logic p);
    RST = r; entry_req = e; exit_req = x; car_passed = p;
    @(posedge CLK);
    #1;
    model_edge(r, e, x, p);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic admit(input int exp_cnt);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("admit_open", {31'd0, gate_open}, 32'd1);
    step(1, 0, 0, 1);
    chk("admit_count", {24'd0, count}, exp_cnt);
    chk("admit_load", {31'd0, load_en}, 32'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  typedef struct {
    logic       r, e, x, p;
    logic [7:0] cnt;
    logic       ld, op, dir, rej, fl, em;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int open_cycles;
    logic saw_load;
    n_checks = 0; n_err = 0;
    RST = 1'b0; entry_req = 1'b0; exit_req = 1'b0; car_passed = 1'b0;

    //           r  e  x  p   cnt   ld op dir rej fl em
    tbl[0]  = '{0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{1, 1, 0, 0, 8'd0, 0, 1, 0, 0, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 8'd0, 0, 1, 0, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 0, 8'd0, 0, 1, 0, 0, 0, 1};
    tbl[6]  = '{1, 1, 0, 1, 8'd1, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 1, 8'd1, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 8'd1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 0, 8'd1, 0, 1, 1, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 1, 8'd0, 1, 0, 1, 0, 0, 1};
    tbl[11] = '{1, 0, 0, 0, 8'd0, 0, 0, 1, 0, 0, 1};
    tbl[12] = '{1, 0, 1, 0, 8'd0, 0, 0, 1, 1, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 8'd0, 0, 0, 1, 0, 0, 1};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].x, tbl[i].p);
      chk($sformatf("vec%0d_count", i), {24'd0, count}, {24'd0, tbl[i].cnt});
      chk($sformatf("vec%0d_flags", i), {27'd0, load_en, gate_open, reject, full, empty},
          {27'd0, tbl[i].ld, tbl[i].op, tbl[i].rej, tbl[i].fl, tbl[i].em});
      if (tbl[i].op) chk($sformatf("vec%0d_dir", i), {31'd0, gate_dir}, {31'd0, tbl[i].dir});
    end

    // Timeout: gate held open exactly GATE cycles with no pass.
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    open_cycles = gate_open ? 1 : 0;
    saw_load = 1'b0;
    for (int i = 0; i < 40 && gate_open; i++) begin
      step(1, 1, 0, 0);
      if (load_en) saw_load = 1'b1;
      if (gate_open) open_cycles++;
    end
    chk("timeout_open_cycles", open_cycles, GATE);
    chk("timeout_gate_closed", {31'd0, gate_open}, 32'd0);
    chk("timeout_count", {24'd0, count}, 32'd0);
    chk("timeout_no_load", {31'd0, saw_load}, 32'd0);

    // Fill to capacity, then refuse one more.
    step(0, 0, 0, 0); step(1, 0, 0, 0);
    for (int k = 1; k <= CAP; k++) admit(k);
    chk("full_flag", {30'd0, full, empty}, 32'd2);
    step(1, 1, 0, 0);
    chk("full_reject", {30'd0, reject, gate_open}, 32'd2);
    step(1, 1, 0, 0);
    chk("full_reject_pulse", {30'd0, reject, gate_open}, 32'd0);
    chk("full_count_held", {24'd0, count}, CAP);

    // Simultaneous entry and exit rise: exit wins.
    step(0, 0, 0, 0); step(1, 0, 0, 0);
    admit(1); admit(2);
    step(1, 1, 1, 0);
    chk("simul_open_dir", {30'd0, gate_open, gate_dir}, 32'd3);
    step(1, 1, 1, 1);
    chk("simul_count", {24'd0, count}, 32'd1);
    chk("simul_load", {31'd0, load_en}, 32'd1);
    step(1, 0, 0, 0); step(1, 0, 0, 0);

    // Reset while the gate is open for an entering car.
    step(0, 0, 0, 0); step(1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) admit(k);
    step(1, 1, 0, 0);
    chk("rstmid_open", {30'd0, gate_open, gate_dir}, 32'd2);
    step(0, 1, 0, 0);
    chk("rstmid_state", {22'd0, count, gate_open, empty}, 32'd1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("rstmid_pass_ignored", {22'd0, count, load_en, gate_open}, 32'd0);
    step(1, 0, 0, 0);

    // Random traffic against the reference model.
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic r, e, x, p;
      r = ($urandom_range(0, 399) != 0);
      e = ($urandom_range(0, 2) == 0);
      x = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 4) == 0);
      step(r, e, x, p);
      chk("rand_outputs",
          {21'd0, count, load_en, gate_open, gate_open & gate_dir, reject, full, empty},
          {21'd0, 8'(m_count), m_load, m_open, m_open & m_dir, m_rej,
           1'(m_count == CAP), 1'(m_count == 0)});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
